dcache_l2c_req_ctrl: RTL and testbench

L1 D-cache miss-request controller that sits directly downstream of the d1 MSHR and upstream of the L2 cache. It picks the next ready MSHR line address, marks that entry as waiting, and issues the line request to L2C over a valid/ready channel. It accepts L2C line answers into a 2-entry refill buffer that drains into the d1 refill path. It also tracks in-flight requests and discards stale answers after a flush.

---
 rtl/dcache_l2c_req_ctrl.sv | 136 +++++++++++++
 tb/tb_dcache_l2c_req_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_l2c_req_ctrl.sv
// L1 D-cache miss-request controller: marks the next ready MSHR line, issues it to L2C,
// buffers L2C answers in a 2-entry refill FIFO and drops answers that are stale after a flush.
module dcache_l2c_req_ctrl #(
    parameter int LINE_ADDR_W = 26,
    parameter int LINE_W      = 512,
    parameter int MAX_PENDING = 4,
    parameter int CNT_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   mshr_req_available_i,
    input  logic [LINE_ADDR_W-1:0] mshr_line_addr_i,
    input  logic                   mshr_add_i,
    output logic                   mshr_put_wait_o,
    output logic                   l2c_req_valid_o,
    input  logic                   l2c_req_ready_i,
    output logic [LINE_ADDR_W-1:0] l2c_req_line_addr_o,
    input  logic                   l2c_ans_valid_i,
    output logic                   l2c_ans_ready_o,
    input  logic [LINE_ADDR_W-1:0] l2c_ans_line_addr_i,
    input  logic [LINE_W-1:0]      l2c_ans_line_i,
    output logic                   refill_valid_o,
    input  logic                   refill_ready_i,
    output logic [LINE_ADDR_W-1:0] refill_line_addr_o,
    output logic [LINE_W-1:0]      refill_line_o,
    output logic [CNT_W-1:0]       inflight_o
);

    typedef enum logic {IDLE, ISSUE} state_e;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PENDING);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_e                 state_q, state_d;
    logic [LINE_ADDR_W-1:0] req_addr_q;
    logic [CNT_W-1:0]       inflight_q, inflight_d;
    logic [CNT_W-1:0]       discard_q, discard_d;
    logic                   mark, req_fire, ans_fire, push, pop;

    logic [LINE_ADDR_W-1:0] buf_addr_q [2];
    logic [LINE_W-1:0]      buf_line_q [2];
    logic                   wr_ptr_q, rd_ptr_q;
    logic [1:0]             cnt_q;

    // MSHR add and clr_all beat put_wait inside the MSHR, so marking must yield to them.
    always_comb begin
        state_d         = state_q;
        mark            = 1'b0;
        l2c_req_valid_o = 1'b0;
        req_fire        = 1'b0;
        case (state_q)
            IDLE: begin
                mark = mshr_req_available_i && !mshr_add_i && !flush_i && (inflight_q < MAX_CNT);
                if (mark) state_d = ISSUE;
            end
            ISSUE: begin
                l2c_req_valid_o = 1'b1;
                req_fire        = l2c_req_ready_i;
                if (l2c_req_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mshr_put_wait_o     = mark;
    assign l2c_req_line_addr_o = req_addr_q;

    assign l2c_ans_ready_o = (discard_q != '0) || (cnt_q != 2'd2);
    assign ans_fire        = l2c_ans_valid_i && l2c_ans_ready_o;
    assign push            = ans_fire && (discard_q == '0) && !flush_i;
    assign pop             = (cnt_q != 2'd0) && refill_ready_i;

    // A request still waiting in ISSUE at flush time will be issued later, so its answer is stale too.
    always_comb begin
        inflight_d = inflight_q;
        if (req_fire) inflight_d = inflight_d + ONE;
        if (ans_fire) inflight_d = inflight_d - ONE;
        discard_d = discard_q;
        if (flush_i)
            discard_d = inflight_d + (((state_q == ISSUE) && !l2c_req_ready_i) ? ONE : '0);
        else if (ans_fire && (discard_q != '0))
            discard_d = discard_q - ONE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            req_addr_q <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            if (mark) req_addr_q <= mshr_line_addr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 2; i++) begin
                buf_addr_q[i] <= '0;
                buf_line_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                buf_addr_q[wr_ptr_q] <= l2c_ans_line_addr_i;
                buf_line_q[wr_ptr_q] <= l2c_ans_line_i;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign refill_valid_o     = (cnt_q != 2'd0);
    assign refill_line_addr_o = buf_addr_q[rd_ptr_q];
    assign refill_line_o      = buf_line_q[rd_ptr_q];
    assign inflight_o         = inflight_q;

    // An answer with nothing in flight means the L2C side lost track of requests.
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(ans_fire && (inflight_q == '0)));

endmodule

// File: tb/tb_dcache_l2c_req_ctrl.sv
// Directed bench for dcache_l2c_req_ctrl: miss issue, blocking, pending limit,
// refill backpressure, flush discard and asynchronous reset.
module tb_dcache_l2c_req_ctrl;

    localparam int AW = 26;
    localparam int LW = 32;
    localparam int CW = 3;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          flush_i, mshr_req_available_i, mshr_add_i;
    logic [AW-1:0] mshr_line_addr_i;
    logic          mshr_put_wait_o;
    logic          l2c_req_valid_o, l2c_req_ready_i;
    logic [AW-1:0] l2c_req_line_addr_o;
    logic          l2c_ans_valid_i, l2c_ans_ready_o;
    logic [AW-1:0] l2c_ans_line_addr_i;
    logic [LW-1:0] l2c_ans_line_i;
    logic          refill_valid_o, refill_ready_i;
    logic [AW-1:0] refill_line_addr_o;
    logic [LW-1:0] refill_line_o;
    logic [CW-1:0] inflight_o;

    int n_vec = 0;
    int n_err = 0;

    dcache_l2c_req_ctrl #(
        .LINE_ADDR_W(AW), .LINE_W(LW), .MAX_PENDING(4), .CNT_W(CW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .mshr_req_available_i(mshr_req_available_i), .mshr_line_addr_i(mshr_line_addr_i),
        .mshr_add_i(mshr_add_i), .mshr_put_wait_o(mshr_put_wait_o),
        .l2c_req_valid_o(l2c_req_valid_o), .l2c_req_ready_i(l2c_req_ready_i),
        .l2c_req_line_addr_o(l2c_req_line_addr_o),
        .l2c_ans_valid_i(l2c_ans_valid_i), .l2c_ans_ready_o(l2c_ans_ready_o),
        .l2c_ans_line_addr_i(l2c_ans_line_addr_i), .l2c_ans_line_i(l2c_ans_line_i),
        .refill_valid_o(refill_valid_o), .refill_ready_i(refill_ready_i),
        .refill_line_addr_o(refill_line_addr_o), .refill_line_o(refill_line_o),
        .inflight_o(inflight_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Mark one line and let L2C accept it on the following cycle.
    task automatic do_req(input logic [AW-1:0] a);
        mshr_req_available_i = 1'b1;
        mshr_line_addr_i     = a;
        tick();
        mshr_req_available_i = 1'b0;
        l2c_req_ready_i      = 1'b1;
        tick();
        l2c_req_ready_i      = 1'b0;
    endtask

    task automatic do_ans(input logic [AW-1:0] a, input logic [LW-1:0] d);
        l2c_ans_valid_i     = 1'b1;
        l2c_ans_line_addr_i = a;
        l2c_ans_line_i      = d;
        tick();
        l2c_ans_valid_i     = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; mshr_req_available_i = 1'b0; mshr_add_i = 1'b0;
        mshr_line_addr_i = '0; l2c_req_ready_i = 1'b0; l2c_ans_valid_i = 1'b0;
        l2c_ans_line_addr_i = '0; l2c_ans_line_i = '0; refill_ready_i = 1'b0;
        #12;
        chk("rst_req_valid", l2c_req_valid_o, 0);
        chk("rst_put_wait", mshr_put_wait_o, 0);
        chk("rst_ans_ready", l2c_ans_ready_o, 1);
        chk("rst_refill_valid", refill_valid_o, 0);
        chk("rst_inflight", inflight_o, 0);
        chk("rst_req_addr", l2c_req_line_addr_o, 0);
        tick();
        rst_ni = 1'b1;
        tick();

        // single miss
        mshr_req_available_i = 1'b1; mshr_line_addr_i = 26'h00ABC;
        #1;
        chk("miss_put_wait_c0", mshr_put_wait_o, 1);
        chk("miss_req_valid_c0", l2c_req_valid_o, 0);
        tick();
        mshr_req_available_i = 1'b0; l2c_req_ready_i = 1'b1;
        #1;
        chk("miss_req_valid_c1", l2c_req_valid_o, 1);
        chk("miss_req_addr", l2c_req_line_addr_o, 26'h00ABC);
        chk("miss_put_wait_c1", mshr_put_wait_o, 0);
        chk("miss_inflight_pre", inflight_o, 0);
        tick();
        l2c_req_ready_i = 1'b0;
        #1;
        chk("miss_inflight_1", inflight_o, 1);
        chk("miss_req_dropped", l2c_req_valid_o, 0);
        l2c_ans_valid_i = 1'b1; l2c_ans_line_addr_i = 26'h00ABC; l2c_ans_line_i = 32'h1111_2222;
        #1;
        chk("miss_ans_ready", l2c_ans_ready_o, 1);
        chk("miss_refill_early", refill_valid_o, 0);
        tick();
        l2c_ans_valid_i = 1'b0;
        #1;
        chk("miss_inflight_0", inflight_o, 0);
        chk("miss_refill_valid", refill_valid_o, 1);
        chk("miss_refill_addr", refill_line_addr_o, 26'h00ABC);
        chk("miss_refill_line", refill_line_o, 32'h1111_2222);
        refill_ready_i = 1'b1;
        tick();
        refill_ready_i = 1'b0;
        #1;
        chk("miss_refill_popped", refill_valid_o, 0);

        // blocking by add
        mshr_req_available_i = 1'b1; mshr_line_addr_i = 26'h0123; mshr_add_i = 1'b1;
        #1;
        chk("blk_put_wait_add", mshr_put_wait_o, 0);
        tick();
        mshr_add_i = 1'b0;
        #1;
        chk("blk_no_capture", l2c_req_valid_o, 0);
        chk("blk_put_wait_resume", mshr_put_wait_o, 1);
        tick();
        mshr_req_available_i = 1'b0; l2c_req_ready_i = 1'b1;
        #1;
        chk("blk_req_addr", l2c_req_line_addr_o, 26'h0123);
        tick();
        l2c_req_ready_i = 1'b0;

        // pending limit
        do_req(26'h0201); do_req(26'h0202); do_req(26'h0203);
        #1;
        chk("lim_inflight_4", inflight_o, 4);
        mshr_req_available_i = 1'b1; mshr_line_addr_i = 26'h0204;
        #1;
        chk("lim_put_wait_blocked", mshr_put_wait_o, 0);
        tick();
        chk("lim_no_issue", l2c_req_valid_o, 0);
        l2c_ans_valid_i = 1'b1; l2c_ans_line_addr_i = 26'h0123; l2c_ans_line_i = 32'hA0A0_0001;
        tick();
        l2c_ans_valid_i = 1'b0;
        #1;
        chk("lim_inflight_3", inflight_o, 3);
        chk("lim_put_wait_resume", mshr_put_wait_o, 1);
        mshr_req_available_i = 1'b0;
        refill_ready_i = 1'b1;
        tick();
        refill_ready_i = 1'b0;

        // refill backpressure
        l2c_ans_valid_i = 1'b1; l2c_ans_line_addr_i = 26'h0B0; l2c_ans_line_i = 32'hD000_0000;
        #1;
        chk("bp_ready_0", l2c_ans_ready_o, 1);
        tick();
        l2c_ans_line_addr_i = 26'h0B1; l2c_ans_line_i = 32'hD000_0001;
        #1;
        chk("bp_ready_1", l2c_ans_ready_o, 1);
        tick();
        l2c_ans_line_addr_i = 26'h0B2; l2c_ans_line_i = 32'hD000_0002;
        #1;
        chk("bp_ready_full", l2c_ans_ready_o, 0);
        tick();
        chk("bp_still_full", l2c_ans_ready_o, 0);
        chk("bp_inflight_1", inflight_o, 1);
        chk("bp_head_0", refill_line_addr_o, 26'h0B0);
        refill_ready_i = 1'b1;
        tick();
        refill_ready_i = 1'b0;
        #1;
        chk("bp_ready_after_pop", l2c_ans_ready_o, 1);
        chk("bp_head_1", refill_line_addr_o, 26'h0B1);
        tick();
        l2c_ans_valid_i = 1'b0;
        #1;
        chk("bp_inflight_0", inflight_o, 0);
        chk("bp_full_again", l2c_ans_ready_o, 0);
        refill_ready_i = 1'b1;
        #1;
        chk("bp_line_1", refill_line_o, 32'hD000_0001);
        tick();
        chk("bp_head_2", refill_line_addr_o, 26'h0B2);
        chk("bp_line_2", refill_line_o, 32'hD000_0002);
        tick();
        refill_ready_i = 1'b0;
        chk("bp_drained", refill_valid_o, 0);

        // flush with a request stuck in ISSUE
        do_req(26'h0301); do_req(26'h0302); do_req(26'h0303);
        do_ans(26'h0301, 32'hF000_0001);
        #1;
        chk("fl_pre_inflight", inflight_o, 2);
        chk("fl_pre_refill", refill_valid_o, 1);
        mshr_req_available_i = 1'b1; mshr_line_addr_i = 26'h0304;
        tick();
        mshr_req_available_i = 1'b0;
        flush_i = 1'b1;
        #1;
        chk("fl_req_held", l2c_req_valid_o, 1);
        tick();
        flush_i = 1'b0;
        #1;
        chk("fl_buf_empty", refill_valid_o, 0);
        chk("fl_req_still", l2c_req_valid_o, 1);
        chk("fl_req_addr", l2c_req_line_addr_o, 26'h0304);
        l2c_req_ready_i = 1'b1;
        tick();
        l2c_req_ready_i = 1'b0;
        #1;
        chk("fl_inflight_3", inflight_o, 3);
        for (int i = 0; i < 3; i++) begin
            l2c_ans_valid_i = 1'b1; l2c_ans_line_addr_i = 26'h0302 + AW'(i);
            l2c_ans_line_i = 32'hEE00_0000 + LW'(i);
            #1;
            chk("fl_disc_ready", l2c_ans_ready_o, 1);
            tick();
            l2c_ans_valid_i = 1'b0;
            #1;
            chk("fl_disc_no_refill", refill_valid_o, 0);
        end
        chk("fl_inflight_0", inflight_o, 0);
        do_req(26'h0400);
        do_ans(26'h0400, 32'h4040_4040);
        #1;
        chk("fl_post_refill", refill_valid_o, 1);
        chk("fl_post_addr", refill_line_addr_o, 26'h0400);
        refill_ready_i = 1'b1;
        tick();
        refill_ready_i = 1'b0;

        // asynchronous reset during ISSUE
        do_req(26'h0500);
        mshr_req_available_i = 1'b1; mshr_line_addr_i = 26'h0501;
        tick();
        mshr_req_available_i = 1'b0;
        chk("ar_pre_valid", l2c_req_valid_o, 1);
        chk("ar_pre_inflight", inflight_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("ar_req_valid", l2c_req_valid_o, 0);
        chk("ar_inflight", inflight_o, 0);
        chk("ar_ans_ready", l2c_ans_ready_o, 1);
        chk("ar_refill_valid", refill_valid_o, 0);
        chk("ar_req_addr", l2c_req_line_addr_o, 0);
        tick();
        rst_ni = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
